// File: rtl/sb_dsp_dma_if.sv
// rtl/sb_dsp_dma_if.sv - ISA-side bus bundle for the Sound Blaster DSP front end.
interface sb_dsp_dma_if;
  logic [9:0] A;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;
  logic       IOR;
  logic       IOW;
  logic       AEN;
  logic       DACK;
  logic       DRQ;
  logic       IRQ;

  modport master (
    output A, D_in, IOR, IOW, AEN, DACK,
    input  D_out, D_oe, DRQ, IRQ
  );

  modport slave (
    input  A, D_in, IOR, IOW, AEN, DACK,
    output D_out, D_oe, DRQ, IRQ
  );
endinterface

// File: rtl/sb_dsp_dma.sv
// rtl/sb_dsp_dma.sv - Sound Blaster DSP port decode, command FSM, DMA fetch and paced PCM playback.
module sb_dsp_dma #(
  parameter logic [9:0]  BASE       = 10'h220,
  parameter int          CLK_PER_US = 50,
  parameter int          FIFO_AW    = 4,
  parameter logic [15:0] VERSION    = 16'h0201
) (
  input  logic         clk,
  input  logic         rst,
  sb_dsp_dma_if.slave  bus,
  output logic [7:0]   pcm,
  output logic         pcm_strobe
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int US_W  = $clog2(CLK_PER_US + 1);

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} cmd_state_t;

  // [0],[1] synchronise the raw strobe, [2] holds the previous synchronised level
  logic [2:0] ior_sh, iow_sh;
  logic ior_fall, ior_rise, iow_rise;
  logic port_en, hit_6, hit_a, hit_c, hit_e;
  logic wr_6, wr_c, rd_a, rd_e, rd_any, dsp_reset, dma_wr;

  cmd_state_t state, state_n;
  logic [7:0] opcode, arg_lo;
  logic       exec;
  logic [7:0] exec_op, exec_lo, exec_hi;
  logic       do_dac, do_tc, do_blk, do_single, do_auto, do_pause, do_resume;
  logic       do_spk_on, do_spk_off, do_exit, do_ver;
  logic [16:0] arg_count;

  logic [7:0] rb [2];
  logic [7:0] rb_n [2];
  logic [1:0] rb_cnt, rb_cnt_n;
  logic [1:0] push_v;
  logic [7:0] push_d [2];
  logic       in_reset;

  logic [7:0]  tc;
  logic [16:0] blk_size, remaining;
  logic        active, auto_init, paused, speaker, drq, irq;
  logic [7:0]  d_out, pcm_q;
  logic        d_oe, pcm_strobe_q;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   fifo_cnt;
  logic fifo_full, fifo_push, fifo_pop, blk_end, drq_ok;

  logic [US_W-1:0] us_cnt;
  logic [7:0]      per_cnt;
  logic            running, us_tick, tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ior_sh <= 3'b111;
      iow_sh <= 3'b111;
    end else begin
      ior_sh <= {ior_sh[1:0], bus.IOR};
      iow_sh <= {iow_sh[1:0], bus.IOW};
    end
  end

  assign ior_fall  = ior_sh[2] & ~ior_sh[1];
  assign ior_rise  = ~ior_sh[2] & ior_sh[1];
  assign iow_rise  = ~iow_sh[2] & iow_sh[1];
  assign port_en   = ~bus.AEN & bus.DACK;
  assign hit_6     = port_en && (bus.A == BASE + 10'h6);
  assign hit_a     = port_en && (bus.A == BASE + 10'hA);
  assign hit_c     = port_en && (bus.A == BASE + 10'hC);
  assign hit_e     = port_en && (bus.A == BASE + 10'hE);
  assign wr_6      = iow_rise & hit_6;
  assign wr_c      = iow_rise & hit_c;
  assign rd_a      = ior_fall & hit_a;
  assign rd_e      = ior_fall & hit_e;
  assign rd_any    = ior_fall & (hit_a | hit_c | hit_e);
  assign dsp_reset = wr_6 & bus.D_in[0];
  assign dma_wr    = iow_rise & ~bus.DACK & (remaining != 17'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opcode <= 8'h00;
      arg_lo <= 8'h00;
    end else begin
      state <= state_n;
      if (wr_c && state == IDLE) opcode <= bus.D_in;
      if (wr_c && state == ARG1) arg_lo <= bus.D_in;
    end
  end

  always_comb begin
    state_n = state;
    exec    = 1'b0;
    exec_op = opcode;
    exec_lo = bus.D_in;
    exec_hi = 8'h00;
    if (dsp_reset) begin
      state_n = IDLE;
    end else if (wr_c) begin
      case (state)
        IDLE: begin
          case (bus.D_in)
            8'h10, 8'h40, 8'h14, 8'h48: state_n = ARG1;
            8'h1C, 8'hD0, 8'hD4, 8'hD1, 8'hD3, 8'hDA, 8'hE1: begin
              exec    = 1'b1;
              exec_op = bus.D_in;
            end
            default: state_n = IDLE;
          endcase
        end
        ARG1: begin
          if (opcode == 8'h14 || opcode == 8'h48) begin
            state_n = ARG2;
          end else begin
            exec    = 1'b1;
            state_n = IDLE;
          end
        end
        ARG2: begin
          exec    = 1'b1;
          exec_lo = arg_lo;
          exec_hi = bus.D_in;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign do_dac     = exec && exec_op == 8'h10;
  assign do_tc      = exec && exec_op == 8'h40;
  assign do_blk     = exec && exec_op == 8'h48;
  assign do_single  = exec && exec_op == 8'h14;
  assign do_auto    = exec && exec_op == 8'h1C;
  assign do_pause   = exec && exec_op == 8'hD0;
  assign do_resume  = exec && exec_op == 8'hD4;
  assign do_spk_on  = exec && exec_op == 8'hD1;
  assign do_spk_off = exec && exec_op == 8'hD3;
  assign do_exit    = exec && exec_op == 8'hDA;
  assign do_ver     = exec && exec_op == 8'hE1;
  assign arg_count  = {1'b0, exec_hi, exec_lo} + 17'd1;

  // Pop first, then up to two pushes; a push into a full buffer is dropped
  always_comb begin
    push_v    = {do_ver, do_ver | (wr_6 & ~bus.D_in[0] & in_reset)};
    push_d[0] = do_ver ? VERSION[15:8] : 8'hAA;
    push_d[1] = VERSION[7:0];
    rb_n      = rb;
    rb_cnt_n  = rb_cnt;
    if (dsp_reset) begin
      rb_cnt_n = 2'd0;
    end else if (rd_a && rb_cnt != 2'd0) begin
      rb_n[0]  = rb[1];
      rb_cnt_n = rb_cnt - 2'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (push_v[i]) begin
        if (rb_cnt_n == 2'd0) begin
          rb_n[0]  = push_d[i];
          rb_cnt_n = 2'd1;
        end else if (rb_cnt_n == 2'd1) begin
          rb_n[1]  = push_d[i];
          rb_cnt_n = 2'd2;
        end
      end
    end
  end

  assign fifo_full = fifo_cnt == (FIFO_AW+1)'(DEPTH);
  assign fifo_push = dma_wr & ~fifo_full;
  assign fifo_pop  = tick && fifo_cnt != '0;
  assign blk_end   = dma_wr && remaining == 17'd1;
  assign drq_ok    = active && !paused && remaining != 17'd0 && !fifo_full;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wp] <= bus.D_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb[0] <= 8'h00;  rb[1] <= 8'h00;  rb_cnt <= 2'd0;  in_reset <= 1'b0;
      d_out <= 8'h00;  d_oe <= 1'b0;
      tc <= 8'hD3;  blk_size <= 17'd1;  remaining <= 17'd0;
      active <= 1'b0;  auto_init <= 1'b0;  paused <= 1'b0;  speaker <= 1'b0;
      drq <= 1'b0;  irq <= 1'b0;  pcm_q <= 8'h00;  pcm_strobe_q <= 1'b0;
      wp <= '0;  rp <= '0;  fifo_cnt <= '0;
    end else begin
      pcm_strobe_q <= 1'b0;
      rb     <= rb_n;
      rb_cnt <= rb_cnt_n;
      if (dsp_reset) in_reset <= 1'b1;
      else if (wr_6) in_reset <= 1'b0;

      if (rd_any) begin
        d_oe <= 1'b1;
        if (rd_a)      d_out <= (rb_cnt != 2'd0) ? rb[0] : 8'hFF;
        else if (rd_e) d_out <= {rb_cnt != 2'd0, 7'h7F};
        else           d_out <= 8'h00;
      end else if (ior_rise) begin
        d_oe <= 1'b0;
      end

      if (do_tc)  tc <= exec_lo;
      if (do_blk) blk_size <= arg_count;
      if (do_spk_on) speaker <= 1'b1;
      else if (do_spk_off) speaker <= 1'b0;
      if (do_pause) paused <= 1'b1;
      else if (do_resume) paused <= 1'b0;

      if (do_dac) begin
        pcm_q        <= exec_lo ^ 8'h80;
        pcm_strobe_q <= 1'b1;
      end else if (fifo_pop) begin
        pcm_q        <= fifo_mem[rp] ^ 8'h80;
        pcm_strobe_q <= 1'b1;
      end

      if (do_single) begin
        remaining <= arg_count;
        auto_init <= 1'b0;
        active    <= 1'b1;
      end else if (do_auto) begin
        remaining <= blk_size;
        auto_init <= 1'b1;
        active    <= 1'b1;
      end else if (dma_wr) begin
        remaining <= (blk_end && auto_init) ? blk_size : remaining - 17'd1;
        if (blk_end && !auto_init) active <= 1'b0;
      end
      if (do_exit) auto_init <= 1'b0;

      if (blk_end) irq <= 1'b1;
      else if (rd_e) irq <= 1'b0;
      drq <= drq_ok & ~dma_wr;

      if (fifo_push) wp <= wp + FIFO_AW'(1);
      if (fifo_pop)  rp <= rp + FIFO_AW'(1);
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
      else if (!fifo_push && fifo_pop) fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);

      // A mid-transfer reset wins over everything above, including a block-end IRQ
      if (dsp_reset) begin
        remaining <= 17'd0;  active <= 1'b0;  auto_init <= 1'b0;
        paused <= 1'b0;  speaker <= 1'b0;  drq <= 1'b0;  irq <= 1'b0;
        wp <= '0;  rp <= '0;  fifo_cnt <= '0;  pcm_strobe_q <= 1'b0;
      end
    end
  end

  // Sample period is (256 - tc) us, so the terminal period count is 255 - tc = ~tc
  assign running = (active || fifo_cnt != '0) && !paused;
  assign us_tick = running && us_cnt == US_W'(CLK_PER_US - 1);
  assign tick    = us_tick && per_cnt >= ~tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt  <= '0;
      per_cnt <= 8'h00;
    end else if (!running || dsp_reset) begin
      us_cnt  <= '0;
      per_cnt <= 8'h00;
    end else if (us_tick) begin
      us_cnt  <= '0;
      per_cnt <= tick ? 8'h00 : per_cnt + 8'h01;
    end else begin
      us_cnt <= us_cnt + US_W'(1);
    end
  end

  assign bus.D_out  = d_out;
  assign bus.D_oe   = d_oe;
  assign bus.DRQ    = drq;
  assign bus.IRQ    = irq;
  assign pcm        = speaker ? pcm_q : 8'h00;
  assign pcm_strobe = pcm_strobe_q;
endmodule

// File: tb/tb_sb_dsp_dma.sv
// tb/tb_sb_dsp_dma.sv - Directed self-checking bench for sb_dsp_dma.
module tb_sb_dsp_dma;
  localparam int US = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pcm;
  logic       pcm_strobe;
  int checks = 0;
  int errors = 0;

  sb_dsp_dma_if bus();

  sb_dsp_dma #(.BASE(10'h220), .CLK_PER_US(US), .FIFO_AW(4), .VERSION(16'h0201)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .pcm(pcm),
    .pcm_strobe(pcm_strobe)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         drq_rises = 0;
  logic       drq_prev = 1'b0;
  logic [7:0] strobe_val [$];
  int         strobe_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pcm_strobe === 1'b1) begin
      strobe_val.push_back(pcm);
      strobe_cyc.push_back(cyc);
    end
    if (bus.DRQ === 1'b1 && drq_prev !== 1'b1) drq_rises++;
    drq_prev = bus.DRQ;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [9:0] addr, input logic [7:0] data);
    bus.A = addr;  bus.D_in = data;  bus.IOW = 1'b0;
    wait_clk(4);
    bus.IOW = 1'b1;
    wait_clk(5);
  endtask

  task automatic io_read(input logic [9:0] addr, output logic [7:0] data, output logic oe);
    bus.A = addr;  bus.IOR = 1'b0;
    wait_clk(5);
    data = bus.D_out;  oe = bus.D_oe;
    bus.IOR = 1'b1;
    wait_clk(5);
  endtask

  task automatic cmd(input logic [7:0] b);
    io_write(10'h22C, b);
  endtask

  task automatic dma_raw(input logic [7:0] data);
    bus.AEN = 1'b1;  bus.DACK = 1'b0;  bus.D_in = data;  bus.IOW = 1'b0;
    wait_clk(4);
    bus.IOW = 1'b1;
    wait_clk(5);
    bus.DACK = 1'b1;  bus.AEN = 1'b0;
    wait_clk(1);
  endtask

  task automatic dma_cycle(input logic [7:0] data);
    int n = 0;
    while (bus.DRQ !== 1'b1 && n < 5000) begin wait_clk(1); n++; end
    checks++;
    if (bus.DRQ !== 1'b1) begin
      errors++;
      $display("FAIL drq_wait: DRQ=%b after %0d clk, expected 1", bus.DRQ, n);
    end else begin
      dma_raw(data);
    end
  endtask

  task automatic test_reset;
    bus.A = 10'h000;  bus.D_in = 8'h00;  bus.IOR = 1'b1;  bus.IOW = 1'b1;
    bus.AEN = 1'b0;  bus.DACK = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    checks += 6;
    if (bus.D_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.D_out); end
    if (bus.D_oe !== 1'b0)   begin errors++; $display("FAIL reset_doe: got %b expected 0", bus.D_oe); end
    if (bus.DRQ !== 1'b0)    begin errors++; $display("FAIL reset_drq: got %b expected 0", bus.DRQ); end
    if (bus.IRQ !== 1'b0)    begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.IRQ); end
    if (pcm !== 8'h00)       begin errors++; $display("FAIL reset_pcm: got %h expected 00", pcm); end
    if (pcm_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", pcm_strobe); end
  endtask

  task automatic test_dsp_reset;
    logic [7:0] v;  logic oe;
    io_write(10'h226, 8'h01);
    io_write(10'h226, 8'h00);
    io_read(10'h22E, v, oe);
    checks += 2;
    if (v !== 8'hFF) begin errors++; $display("FAIL status_avail: got %h expected FF", v); end
    if (oe !== 1'b1) begin errors++; $display("FAIL read_doe: got %b expected 1", oe); end
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'hAA) begin errors++; $display("FAIL reset_ack: got %h expected AA", v); end
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL empty_read: got %h expected FF", v); end
    io_read(10'h22C, v, oe);
    checks += 2;
    if (v !== 8'h00) begin errors++; $display("FAIL write_status: got %h expected 00", v); end
    if (bus.D_oe !== 1'b0) begin errors++; $display("FAIL doe_release: got %b expected 0", bus.D_oe); end
  endtask

  task automatic test_version;
    logic [7:0] v;  logic oe;
    cmd(8'hE1);
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL version_hi: got %h expected 02", v); end
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL version_lo: got %h expected 01", v); end
    io_read(10'h22E, v, oe);
    checks++;
    if (v !== 8'h7F) begin errors++; $display("FAIL status_empty: got %h expected 7F", v); end
    cmd(8'hE1);
    cmd(8'hE1);
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL overflow_hi: got %h expected 02", v); end
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL overflow_lo: got %h expected 01", v); end
    io_read(10'h22A, v, oe);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL overflow_drop: got %h expected FF", v); end
  endtask

  task automatic test_direct_dac;
    cmd(8'hD1);
    strobe_val.delete();
    cmd(8'h10);
    cmd(8'hC0);
    checks += 2;
    if (strobe_val.size() != 1) begin
      errors++; $display("FAIL dac_strobes: got %0d expected 1", strobe_val.size());
    end else if (strobe_val[0] !== 8'h40) begin
      errors++; $display("FAIL dac_strobe_val: got %h expected 40", strobe_val[0]);
    end
    if (pcm !== 8'h40) begin errors++; $display("FAIL dac_pcm: got %h expected 40", pcm); end
    cmd(8'hD3);
    checks++;
    if (pcm !== 8'h00) begin errors++; $display("FAIL speaker_off: got %h expected 00", pcm); end
    cmd(8'h77);
    cmd(8'hD1);
    checks++;
    if (pcm !== 8'h40) begin errors++; $display("FAIL unknown_op: got %h expected 40", pcm); end
  endtask

  task automatic test_single_dma;
    logic [7:0] v;  logic oe;
    int r0, n;
    cmd(8'h40);  cmd(8'h9C);
    r0 = drq_rises;
    strobe_val.delete();  strobe_cyc.delete();
    cmd(8'h14);  cmd(8'h03);  cmd(8'h00);
    for (int i = 0; i < 4; i++) dma_cycle(8'h80 + 8'(i * 16));
    checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", bus.IRQ); end
    n = 0;
    while (strobe_val.size() < 4 && n < 3000) begin wait_clk(1); n++; end
    wait_clk(600);
    checks += 2;
    if (drq_rises - r0 != 4) begin errors++; $display("FAIL single_drqs: got %0d expected 4", drq_rises - r0); end
    if (strobe_val.size() != 4) begin
      errors++; $display("FAIL single_samples: got %0d expected 4", strobe_val.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (strobe_val[i] !== 8'(i * 16)) begin
          errors++; $display("FAIL single_pcm%0d: got %h expected %h", i, strobe_val[i], 8'(i * 16));
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (strobe_cyc[i+1] - strobe_cyc[i] != 100 * US) begin
          errors++; $display("FAIL single_spacing%0d: got %0d expected %0d", i, strobe_cyc[i+1] - strobe_cyc[i], 100 * US);
        end
      end
    end
    io_read(10'h22E, v, oe);
    checks += 2;
    if (v !== 8'h7F) begin errors++; $display("FAIL single_status: got %h expected 7F", v); end
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", bus.IRQ); end
    dma_raw(8'h55);
    wait_clk(600);
    checks += 2;
    if (strobe_val.size() != 4) begin errors++; $display("FAIL zero_remaining_push: got %0d expected 4", strobe_val.size()); end
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL zero_remaining_irq: got %b expected 0", bus.IRQ); end
  endtask

  task automatic test_auto_init;
    logic [7:0] v;  logic oe;
    int r0;
    cmd(8'h40);  cmd(8'hFF);
    cmd(8'h48);  cmd(8'h01);  cmd(8'h00);
    cmd(8'h1C);
    for (int k = 0; k < 2; k++) begin
      dma_cycle(8'h10);
      dma_cycle(8'h20);
      checks++;
      if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL auto_irq%0d: got %b expected 1", k, bus.IRQ); end
      io_read(10'h22E, v, oe);
      checks++;
      if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL auto_irq_clr%0d: got %b expected 0", k, bus.IRQ); end
    end
    checks++;
    if (bus.DRQ !== 1'b1) begin errors++; $display("FAIL auto_drq_continue: got %b expected 1", bus.DRQ); end
    cmd(8'hDA);
    dma_cycle(8'h30);
    dma_cycle(8'h40);
    checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL exit_irq: got %b expected 1", bus.IRQ); end
    r0 = drq_rises;
    wait_clk(300);
    checks += 2;
    if (bus.DRQ !== 1'b0) begin errors++; $display("FAIL exit_drq: got %b expected 0", bus.DRQ); end
    if (drq_rises != r0) begin errors++; $display("FAIL exit_drq_rises: got %0d expected %0d", drq_rises, r0); end
    io_read(10'h22E, v, oe);
  endtask

  task automatic test_pause;
    int s_start, s0, r0;
    s_start = strobe_val.size();
    cmd(8'h14);  cmd(8'h03);  cmd(8'h00);
    dma_cycle(8'h11);
    dma_cycle(8'h22);
    cmd(8'hD0);
    s0 = strobe_val.size();
    r0 = drq_rises;
    checks++;
    if (bus.DRQ !== 1'b0) begin errors++; $display("FAIL pause_drq: got %b expected 0", bus.DRQ); end
    wait_clk(1000 * US);
    checks += 2;
    if (strobe_val.size() != s0) begin errors++; $display("FAIL pause_strobes: got %0d expected %0d", strobe_val.size(), s0); end
    if (drq_rises != r0) begin errors++; $display("FAIL pause_drq_rises: got %0d expected %0d", drq_rises, r0); end
    cmd(8'hD4);
    dma_cycle(8'h33);
    dma_cycle(8'h44);
    checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL resume_irq: got %b expected 1", bus.IRQ); end
    wait_clk(300);
    checks += 3;
    if (drq_rises != r0 + 2) begin errors++; $display("FAIL resume_drqs: got %0d expected %0d", drq_rises, r0 + 2); end
    if (strobe_val.size() != s_start + 4) begin errors++; $display("FAIL resume_samples: got %0d expected %0d", strobe_val.size(), s_start + 4); end
    if (bus.DRQ !== 1'b0) begin errors++; $display("FAIL resume_drq_end: got %b expected 0", bus.DRQ); end
  endtask

  task automatic test_rst;
    int n;
    checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL pre_rst_irq: got %b expected 1", bus.IRQ); end
    cmd(8'h40);  cmd(8'h9C);
    cmd(8'h14);  cmd(8'h03);  cmd(8'h00);
    dma_cycle(8'h11);
    n = 0;
    while (bus.DRQ !== 1'b1 && n < 100) begin wait_clk(1); n++; end
    checks++;
    if (bus.DRQ !== 1'b1) begin errors++; $display("FAIL pre_rst_drq: got %b expected 1", bus.DRQ); end
    rst = 1'b1;
    wait_clk(1);
    checks += 2;
    if (bus.DRQ !== 1'b0) begin errors++; $display("FAIL rst_drq: got %b expected 0", bus.DRQ); end
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", bus.IRQ); end
    rst = 1'b0;
    wait_clk(2);
    cmd(8'hD1);
    strobe_val.delete();  strobe_cyc.delete();
    cmd(8'h14);  cmd(8'h01);  cmd(8'h00);
    dma_cycle(8'hC0);
    dma_cycle(8'hD0);
    n = 0;
    while (strobe_val.size() < 2 && n < 2000) begin wait_clk(1); n++; end
    wait_clk(400);
    checks++;
    if (strobe_val.size() != 2) begin
      errors++; $display("FAIL rst_samples: got %0d expected 2", strobe_val.size());
    end else begin
      checks += 3;
      if (strobe_val[0] !== 8'h40) begin errors++; $display("FAIL rst_fifo_empty: got %h expected 40", strobe_val[0]); end
      if (strobe_val[1] !== 8'h50) begin errors++; $display("FAIL rst_pcm1: got %h expected 50", strobe_val[1]); end
      if (strobe_cyc[1] - strobe_cyc[0] != 45 * US) begin
        errors++; $display("FAIL rst_tc_default: got %0d expected %0d", strobe_cyc[1] - strobe_cyc[0], 45 * US);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dsp_reset();
    test_version();
    test_direct_dac();
    test_single_dma();
    test_auto_init();
    test_pause();
    test_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
